// File: rtl/sm_pkg.sv
// Shared types and the sign-magnitude add rule used by the accumulator datapath.
package sm_pkg;

  localparam int SM_W    = 32;
  localparam int N_DEF   = 4;
  localparam int MAG_MAX = 2**(N_DEF-1) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int cnt_width(input int acc_len);
    return $clog2(acc_len + 1);
  endfunction

  // Operands are n-bit sign-magnitude words zero-extended to SM_W; result is {ovf, sum}.
  function automatic logic [SM_W:0] sm_add(input logic [SM_W-1:0] a,
                                           input logic [SM_W-1:0] b,
                                           input int              n);
    logic [SM_W-1:0] mmax;
    logic [SM_W-1:0] ma;
    logic [SM_W-1:0] mb;
    logic [SM_W-1:0] mag;
    logic            sa;
    logic            sb;
    logic            so;
    logic            ov;
    mmax = (32'd1 << (n - 1)) - 32'd1;
    ma   = a & mmax;
    mb   = b & mmax;
    sa   = a[n-1] & (ma != 32'd0);
    sb   = b[n-1] & (mb != 32'd0);
    ov   = 1'b0;
    if (sa == sb) begin
      mag = ma + mb;
      so  = sa;
      if (mag > mmax) begin
        mag = mmax;
        ov  = 1'b1;
      end else begin
        ov  = 1'b0;
      end
    end else if (ma >= mb) begin
      mag = ma - mb;
      so  = sa;
    end else begin
      mag = mb - ma;
      so  = sb;
    end
    if (mag == 32'd0) begin
      so = 1'b0;
    end else begin
      so = so;
    end
    return {ov, ({31'd0, so} << (n - 1)) | mag};
  endfunction

endpackage

// File: rtl/sm_sat_add.sv
// Combinational saturating sign-magnitude adder; never produces -0.
module sm_sat_add
  import sm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] res,
  output logic         ovf
);

  logic [SM_W:0] w_full;
  logic          w_unused;

  assign w_full   = sm_add(SM_W'(op_a), SM_W'(op_b), N);
  assign res      = w_full[N-1:0];
  assign ovf      = w_full[SM_W];
  assign w_unused = &{1'b0, w_full[SM_W-1:N]};

endmodule

// File: rtl/sm_accum.sv
// Framed sign-magnitude accumulator: sums a beat stream, presents total, sticky ovf and count.
module sm_accum
  import sm_pkg::*;
#(
  parameter int N       = 4,
  parameter int ACC_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [N-1:0]                 in_data,
  input  logic                         in_last,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [N-1:0]                 out_data,
  output logic                         out_ovf,
  output logic [$clog2(ACC_LEN+1)-1:0] out_cnt
);

  localparam int            CW      = cnt_width(ACC_LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] LEN_M1  = CW'(ACC_LEN - 1);

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_in_rdy;
  logic          r_out_vld;
  logic [N-1:0]  r_out_data;
  logic          r_out_ovf;
  logic [CW-1:0] r_out_cnt;

  logic [N-1:0]  w_sum;
  logic          w_sum_ovf;
  logic          w_accept;
  logic          w_close;

  sm_sat_add #(.N(N)) u_add (
    .op_a (r_acc),
    .op_b (in_data),
    .res  (w_sum),
    .ovf  (w_sum_ovf)
  );

  assign w_accept = in_vld & r_in_rdy;
  // In IDLE the count is zero, so ACC_LEN==1 closes on the first beat here as well.
  assign w_close  = in_last | (r_cnt == LEN_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_in_rdy   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_out_cnt  <= '0;
    end else if (clr) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_in_rdy   <= 1'b1;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_out_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          r_in_rdy <= 1'b1;
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_ONE;
            r_ovf <= r_ovf | w_sum_ovf;
            if (w_close) begin
              r_state    <= HOLD;
              r_in_rdy   <= 1'b0;
              r_out_vld  <= 1'b1;
              r_out_data <= w_sum;
              r_out_ovf  <= r_ovf | w_sum_ovf;
              r_out_cnt  <= r_cnt + CNT_ONE;
            end else begin
              r_state <= ACC;
            end
          end else begin
            r_state <= r_state;
          end
        end
        HOLD: begin
          if (out_rdy) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
            r_out_cnt  <= '0;
          end else begin
            r_in_rdy <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_in_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy   = r_in_rdy;
  assign out_vld  = r_out_vld;
  assign out_data = r_out_data;
  assign out_ovf  = r_out_ovf;
  assign out_cnt  = r_out_cnt;

endmodule

// File: tb/tb_sm_accum.sv
// Scoreboard bench for sm_accum: integer reference model feeds a queue, a monitor checks results.
module tb_sm_accum;

  localparam int N       = 4;
  localparam int ACC_LEN = 8;
  localparam int CW      = $clog2(ACC_LEN + 1);

  typedef struct packed {
    logic [N-1:0]  d;
    logic          o;
    logic [CW-1:0] c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [N-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [N-1:0]  out_data;
  logic          out_ovf;
  logic [CW-1:0] out_cnt;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_m = 0;
  int   cnt_m = 0;
  logic ovf_m = 1'b0;
  logic bp_on = 1'b0;

  sm_accum #(.N(N), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int sm2int(input logic [N-1:0] v);
    int mag;
    mag = int'(v[N-2:0]);
    return v[N-1] ? -mag : mag;
  endfunction

  function automatic logic [N-1:0] int2sm(input int v);
    logic [N-1:0] r;
    if (v < 0) r = {1'b1, 3'(-v)};
    else       r = {1'b0, 3'(v)};
    return r;
  endfunction

  task automatic model_clear();
    acc_m = 0;
    cnt_m = 0;
    ovf_m = 1'b0;
  endtask

  // Reference: integer sum clamped to +/-(2^(N-1)-1) per beat.
  task automatic model_beat(input logic [N-1:0] d, input logic l);
    exp_t e;
    int   lim;
    lim   = 2**(N-1) - 1;
    acc_m = acc_m + sm2int(d);
    if (acc_m > lim)  begin acc_m = lim;  ovf_m = 1'b1; end
    if (acc_m < -lim) begin acc_m = -lim; ovf_m = 1'b1; end
    cnt_m++;
    if (l || cnt_m == ACC_LEN) begin
      e.d = int2sm(acc_m);
      e.o = ovf_m;
      e.c = CW'(cnt_m);
      q.push_back(e);
      model_clear();
    end
  endtask

  task automatic send(input logic [N-1:0] d, input logic l);
    int tmo;
    in_data = d;
    in_last = l;
    in_vld  = 1'b1;
    tmo     = 0;
    @(negedge clk);
    while (!in_rdy && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (!in_rdy) check("send_timeout", 0, 1);
    @(posedge clk);
    model_beat(d, l);
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  // Monitor: compare each consumed result against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_vld && out_rdy) begin
        if (q.size() == 0) begin
          check("unexpected_out_vld", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_data", int'(out_data), int'(e.d));
          check("out_ovf", int'(out_ovf), int'(e.o));
          check("out_cnt", int'(out_cnt), int'(e.c));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_on) out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int tmo;
    #12;
    check("rst_in_rdy", int'(in_rdy), 0);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_in_rdy", int'(in_rdy), 1);

    send(4'b1111, 1'b0);
    send(4'b0110, 1'b1);
    check("latency_out_vld", int'(out_vld), 1);
    repeat (2) @(posedge clk); #1;

    send(4'b0101, 1'b0);
    send(4'b0101, 1'b1);
    send(4'b1010, 1'b1);
    send(4'b0011, 1'b0);
    send(4'b1011, 1'b1);
    send(4'b1000, 1'b1);
    repeat (2) @(posedge clk); #1;

    out_rdy = 1'b0;
    for (int i = 0; i < ACC_LEN; i++) send(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_out_vld", int'(out_vld), 1);
      check("hold_in_rdy", int'(in_rdy), 0);
      check("hold_data", int'(out_data), 7);
      check("hold_ovf", int'(out_ovf), 1);
      check("hold_cnt", int'(out_cnt), ACC_LEN);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("bubble_in_rdy", int'(in_rdy), 1);

    send(4'b0010, 1'b0);
    send(4'b0011, 1'b0);
    in_vld = 1'b1; in_data = 4'b0001; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_vld = 1'b0;
    model_clear();
    send(4'b0100, 1'b1);
    repeat (2) @(posedge clk); #1;

    out_rdy = 1'b0;
    send(4'b0011, 1'b1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    q.delete();
    model_clear();
    check("clr_hold_out_vld", int'(out_vld), 0);
    out_rdy = 1'b1;

    send(4'b0010, 1'b0);
    send(4'b0011, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_out_vld", int'(out_vld), 0);
    check("arst_out_data", int'(out_data), 0);
    check("arst_out_cnt", int'(out_cnt), 0);
    check("arst_in_rdy", int'(in_rdy), 0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_out_vld", int'(out_vld), 0);
    end
    @(posedge clk); #1;

    bp_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
    end
    tmo = 0;
    while (q.size() != 0 && tmo < 500) begin
      @(posedge clk);
      tmo++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    bp_on = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
